// File: rtl/detection_result_serializer.sv
// detection_result_serializer
// Captures detector results tagged with the current test ID, buffers them in a
// small FIFO and emits each one as a framed byte stream over valid/ready.
// Frame: SYNC, {test_id, 3'b000, attack}, major[31:0] MSB first, minor[31:0] MSB first,
// and an XOR checksum byte when RESULT_SERIALIZER_CKSUM_EN is defined (10 bytes otherwise).
module detection_result_serializer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          res_valid,
    input  logic                          res_attack,
    input  logic [31:0]                   res_major,
    input  logic [31:0]                   res_minor,
    input  logic [3:0]                    res_test_id,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    input  logic                          clr_stats,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow,
    output logic [7:0]                    drop_count
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned ENTRY_W = 69;
`ifdef RESULT_SERIALIZER_CKSUM_EN
    localparam int unsigned NB      = 11;
`else
    localparam int unsigned NB      = 10;
`endif
    localparam int unsigned FRAME_W = NB * 8;
    localparam logic [3:0]  IDX_LAST = 4'(NB - 1);

    typedef enum logic {StIdle, StSend} state_t;

    // Entry layout: {test_id[3:0], attack, major[31:0], minor[31:0]}
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    state_t             r_state;
    logic [FRAME_W-1:0] r_frame;
    logic [3:0]         r_byte_idx;
    logic               r_tx_valid;
    logic               r_busy;
    logic               r_overflow;
    logic [7:0]         r_drop_count;

    logic [ENTRY_W-1:0] w_head;
    logic [7:0]         w_b1;
    logic [FRAME_W-1:0] w_head_frame;
    logic               w_full;
    logic               w_nonempty;
    logic               w_push;
    logic               w_drop;
    logic               w_last_accept;
    logic               w_pop;

    // Full is judged on the registered count, before any same-cycle pop.
    assign w_full        = (r_count == CW'(FIFO_DEPTH));
    assign w_nonempty    = (r_count != '0);
    assign w_push        = res_valid && !w_full;
    assign w_drop        = res_valid && w_full;
    assign w_last_accept = (r_state == StSend) && r_tx_valid && tx_ready
                           && (r_byte_idx == IDX_LAST);
    assign w_pop         = w_nonempty && ((r_state == StIdle) || w_last_accept);

    assign w_head = r_mem[r_rd_ptr];
    assign w_b1   = {w_head[68:65], 3'b000, w_head[64]};

`ifdef RESULT_SERIALIZER_CKSUM_EN
    logic [7:0] w_cksum;

    // Checksum covers B1..B9: the header byte and both score words.
    always_comb begin
        w_cksum = w_b1;
        for (int k = 0; k < 8; k++) begin
            w_cksum = w_cksum ^ w_head[k*8 +: 8];
        end
    end

    assign w_head_frame = {SYNC_BYTE, w_b1, w_head[63:0], w_cksum};
`else
    assign w_head_frame = {SYNC_BYTE, w_b1, w_head[63:0]};
`endif

    // FIFO storage; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {res_test_id, res_attack, res_major, res_minor};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter; a coincident drop wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
        end else if (clr_stats) begin
            r_overflow   <= w_drop;
            r_drop_count <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end
    end

    // Frame FSM: load a frame from the FIFO head, shift one byte out per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_frame    <= '0;
            r_byte_idx <= 4'd0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_nonempty) begin
                        r_frame    <= w_head_frame;
                        r_byte_idx <= 4'd0;
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= StSend;
                    end
                end
                StSend: begin
                    if (r_tx_valid && tx_ready) begin
                        if (r_byte_idx == IDX_LAST) begin
                            if (w_nonempty) begin
                                // Back-to-back: next frame starts without a bubble.
                                r_frame    <= w_head_frame;
                                r_byte_idx <= 4'd0;
                            end else begin
                                r_tx_valid <= 1'b0;
                                r_busy     <= 1'b0;
                                r_state    <= StIdle;
                            end
                        end else begin
                            r_frame    <= r_frame << 8;
                            r_byte_idx <= r_byte_idx + 4'd1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign tx_data    = r_frame[FRAME_W-1 -: 8];
    assign tx_valid   = r_tx_valid;
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_detection_result_serializer.sv
// Self-checking bench for detection_result_serializer: expected frame bytes are
// queued when a result is strobed and compared as the DUT hands bytes to the sink.
module tb_detection_result_serializer;

`ifdef RESULT_SERIALIZER_CKSUM_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic        res_valid;
    logic        res_attack;
    logic [31:0] res_major;
    logic [31:0] res_minor;
    logic [3:0]  res_test_id;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        clr_stats;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    int          n_checks;
    int          n_fail;
    logic [7:0]  exp_q[$];

    detection_result_serializer #(
        .FIFO_DEPTH (4),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .res_valid   (res_valid),
        .res_attack  (res_attack),
        .res_major   (res_major),
        .res_minor   (res_minor),
        .res_test_id (res_test_id),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .clr_stats   (clr_stats),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build the expected frame for one result and append it to the scoreboard.
    task automatic expect_frame(input logic [3:0] tid, input logic atk,
                                input logic [31:0] maj, input logic [31:0] mnr);
        logic [7:0] b [11];
        logic [7:0] ck;
        b[0] = 8'hA5;
        b[1] = {tid, 3'b000, atk};
        for (int k = 0; k < 4; k++) begin
            b[2 + k] = maj[31 - 8*k -: 8];
            b[6 + k] = mnr[31 - 8*k -: 8];
        end
        ck = 8'h00;
        for (int k = 1; k < 10; k++) ck = ck ^ b[k];
        b[10] = ck;
        for (int k = 0; k < NB; k++) exp_q.push_back(b[k]);
    endtask

    // Drive one result strobe for a single cycle; queue its frame if it should be kept.
    task automatic strobe(input logic [3:0] tid, input logic atk, input logic [31:0] maj,
                          input logic [31:0] mnr, input bit keep, input bit clr);
        res_test_id = tid;
        res_attack  = atk;
        res_major   = maj;
        res_minor   = mnr;
        res_valid   = 1'b1;
        clr_stats   = clr;
        if (keep) expect_frame(tid, atk, maj, mnr);
        tick();
        res_valid = 1'b0;
        clr_stats = 1'b0;
    endtask

    // Sink-side monitor: scoreboard compare on every accepted byte, stability while stalled.
    logic [7:0] prev_data;
    logic       prev_stall;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                n_checks++;
                if (tx_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: tx_data=%h required %h", tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: tx_data=%h required none", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        n_fail++;
                        $display("FAIL frame_byte: tx_data=%h required %h", tx_data, e);
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Let the DUT drain with tx_ready=1; an expired budget counts as a failure.
    task automatic wait_drain(input string name);
        tx_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && !tx_valid && !busy) break;
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: pending=%0d tx_valid=%b busy=%b required 0 0 0",
                     name, exp_q.size(), tx_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: %h required 00", tx_data); end
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: %b required 0", tx_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b required 0", busy); end
        n_checks++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: %0d required 0", fifo_count); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: %b required 0", overflow); end
        n_checks++;
        if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop_count: %0d required 0", drop_count); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        tx_ready = 1'b1;
        strobe(4'd3, 1'b1, 32'h12345678, 32'h000000FF, 1'b1, 1'b0);
        n_checks++;
        if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count_t0: %0d required 1", fifo_count); end
        n_checks++;
        if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_t0: %b required 0", tx_valid); end
        tick();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_first_byte: valid=%b data=%h required 1 a5", tx_valid, tx_data);
        end
        n_checks++;
        if (busy !== 1'b1 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_busy_pop: busy=%b count=%0d required 1 0", busy, fifo_count);
        end
        repeat (NB - 1) tick();
        n_checks++;
        if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_last_valid: %b required 1", tx_valid); end
        tick();
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_end: valid=%b busy=%b pending=%0d required 0 0 0",
                     tx_valid, busy, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit busy_ok;
        bit pattern [4];
        int i;
        pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
        busy_ok  = 1'b1;
        tx_ready = 1'b1;
        strobe(4'd3, 1'b1, 32'h12345678, 32'h000000FF, 1'b1, 1'b0);
        i = 0;
        while (i < 300 && (exp_q.size() != 0 || tx_valid)) begin
            tx_ready = pattern[i % 4];
            if (tx_valid && !busy) busy_ok = 1'b0;
            tick();
            i++;
        end
        n_checks++;
        if (!busy_ok) begin n_fail++; $display("FAIL bp_busy: busy dropped mid-frame required 1"); end
        wait_drain("bp");
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            strobe(4'(i), 1'(i), 32'h1000_0000 * i + 32'h0102, 32'hA0B0_0000 + i, i <= 5, 1'b0);
        end
        n_checks++;
        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: %0d required 4", fifo_count); end
        n_checks++;
        if (drop_count !== 8'd2) begin n_fail++; $display("FAIL ovf_drops: %0d required 2", drop_count); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: %b required 1", overflow); end
        n_checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL ovf_in_flight: valid=%b busy=%b data=%h required 1 1 a5",
                     tx_valid, busy, tx_data);
        end
        wait_drain("ovf");
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL ovf_clear: overflow=%b drops=%0d required 0 0", overflow, drop_count);
        end
    endtask

    task automatic test_clr_collision();
        tx_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            strobe(4'(i + 8), 1'b0, $urandom, $urandom, i <= 5, 1'b0);
        end
        n_checks++;
        if (drop_count !== 8'd2) begin n_fail++; $display("FAIL coll_pre_drops: %0d required 2", drop_count); end
        strobe(4'hF, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (drop_count !== 8'd1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_stats: drops=%0d overflow=%b required 1 1", drop_count, overflow);
        end
        wait_drain("coll");
    endtask

    task automatic test_back_to_back();
        int cnt;
        int guard;
        cnt = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe(4'(i + 5), 1'(i), $urandom, $urandom, 1'b1, 1'b0);
            if (tx_valid) cnt++;
        end
        guard = 0;
        while (tx_valid && guard < 200) begin
            tick();
            if (tx_valid) cnt++;
            guard++;
        end
        n_checks++;
        if (cnt != 3 * NB) begin n_fail++; $display("FAIL b2b_valid_cycles: %0d required %0d", cnt, 3 * NB); end
        n_checks++;
        if (fifo_count !== 3'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_end: count=%0d pending=%0d required 0 0", fifo_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        tx_ready = 1'b1;
        strobe(4'd1, 1'b0, 32'h0BAD_F00D, 32'h1111_2222, 1'b1, 1'b0);
        strobe(4'd2, 1'b1, 32'h3333_4444, 32'h5555_6666, 1'b1, 1'b0);
        n_checks++;
        if (fifo_count !== 3'd1 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: count=%0d valid=%b required 1 1", fifo_count, tx_valid);
        end
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: valid=%b count=%0d busy=%b required 0 0 0",
                     tx_valid, fifo_count, busy);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        strobe(4'd7, 1'b1, 32'hCAFE_0001, 32'h0000_0002, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL rst_restart: valid=%b data=%h required 1 a5", tx_valid, tx_data);
        end
        wait_drain("rst");
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        prev_stall  = 1'b0;
        prev_data   = 8'h00;
        rst_n       = 1'b0;
        res_valid   = 1'b0;
        res_attack  = 1'b0;
        res_major   = 32'h0;
        res_minor   = 32'h0;
        res_test_id = 4'h0;
        tx_ready    = 1'b0;
        clr_stats   = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_clr_collision();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/detection_result_serializer.md
Name: detection_result_serializer

Overview:
- Output-side counterpart of the feature loader: captures each detector result from top_pipeline (valid_out, attack_detected, major_score, minor_score) and tags it with the current test ID.
- Buffers results in a small FIFO and emits each one as a framed byte stream over a valid/ready interface, for a UART TX or a debug bridge.
- Sits between top_pipeline and the board's serial transmitter in the FPGA test build.

Parameters:
- FIFO_DEPTH, 4, result entries buffered (power of two, ≥2).
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- res_valid  in  1  one-cycle result strobe (driven from top_pipeline valid_out).
- res_attack  in  1  attack_detected.
- res_major  in  32  major_score.
- res_minor  in  32  minor_score.
- res_test_id  in  4  test ID current at capture.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte.
- clr_stats  in  1  clears overflow and drop_count.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries pending (excludes frame in flight).
- busy  out  1  frame in flight.
- overflow  out  1  sticky: a result was dropped.
- drop_count  out  8  dropped results, saturating at 255.

Behaviour:
- Reset values: tx_data=0, tx_valid=0, busy=0, fifo_count=0, overflow=0, drop_count=0. FSM returns to IDLE and FIFO pointers clear. A frame in flight mid-reset is abandoned; no partial resume.
- Capture: on res_valid, if fifo_count<FIFO_DEPTH, push {test_id, attack, major, minor}.
  - Otherwise drop the result, set overflow, and increment drop_count (saturating).
  - Full is evaluated before any same-cycle pop, so a push to a full FIFO is dropped even when a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves fifo_count unchanged.
- clr_stats: clears overflow and drop_count next cycle. If a drop coincides with clr_stats, the result is overflow=1 and drop_count=1.
- Frame, bytes in order:
  - B0 = SYNC_BYTE
  - B1 = {test_id[3:0], 3'b000, attack}
  - B2..B5 = major, MSB first
  - B6..B9 = minor, MSB first
  - B10 = XOR of B1..B9 (checksum, see Optional Feature)
- FSM states: IDLE, SEND.
  - IDLE: if FIFO is non-empty, pop the head into the frame shift register, set byte_idx=0, and go to SEND. tx_valid and busy assert the following cycle.
  - SEND: tx_data = frame byte[byte_idx]; tx_valid=1.
    - On tx_valid&&tx_ready with byte_idx < last, increment byte_idx.
    - On tx_valid&&tx_ready with byte_idx == last: if FIFO is non-empty, pop the next entry and keep tx_valid=1 with B0 of the new frame on the next cycle (back-to-back, no bubble). Otherwise go to IDLE with tx_valid=0 and busy=0.
- Handshake rules: while tx_valid && !tx_ready, tx_data is held stable. tx_valid never drops mid-frame. tx_ready is ignored when tx_valid=0.
- Latency: with an empty FIFO, idle FSM and tx_ready=1:
  - res_valid at edge T;
  - fifo_count=1 after T;
  - pop at T+1;
  - tx_valid=1 with B0 after T+1 (2 cycles);
  - last byte accepted 10 cycles later (11 with checksum).
- Results are never reordered.

Optional Feature:
- Macro RESULT_SERIALIZER_CKSUM_EN.
- Defined: frame is 11 bytes, B10 = XOR checksum.
- Undefined: frame is 10 bytes (B0..B9), no checksum logic, last byte is B9.

Test Plan:
- Single result, tx_ready=1, test_id=3, attack=1, major=32'h12345678, minor=32'h000000FF -> bytes A5 31 12 34 56 78 00 00 00 FF C6 (C6 only with CKSUM_EN); tx_valid rises 2 cycles after res_valid.
- Backpressure: same result, tx_ready toggles 1,0,0,1,… -> tx_data stable whenever ready=0; identical byte sequence; busy=1 throughout frame.
- Overflow: FIFO_DEPTH=4, tx_ready=0, 7 res_valid strobes on consecutive cycles -> first result in flight, fifo_count=4, drop_count=2, overflow=1; with ready then 1 -> 5 frames in order of results 1-5; then clr_stats -> overflow=0, drop_count=0.
- Back-to-back: 3 results queued, tx_ready=1 -> 33 consecutive tx_valid cycles (30 without CKSUM_EN), no gap between frames, fifo_count reaches 0.
- Reset mid-frame: assert rst_n=0 after B4 accepted -> tx_valid=0, fifo_count=0 immediately; after release, new result -> frame starts with A5.
- Drop on clr_stats collision: FIFO full, res_valid and clr_stats in same cycle -> drop_count=1, overflow=1.
